// File: rtl/fixed_point_saturating_subtractor_pkg.sv
// Fixed-point constants and saturation codes shared by the saturating adder and subtractor.
// Widths up to FP_MAX_W bits are supported by the constant helpers.
package fixed_point_saturating_subtractor_pkg;

  localparam int FP_MAX_W = 64;

  // Top two bits of the (W+1)-bit raw result that signal overflow.
  localparam logic [1:0] SAT_CODE_POS = 2'b01;
  localparam logic [1:0] SAT_CODE_NEG = 2'b10;

  function automatic logic [FP_MAX_W-1:0] fp_max(input int w);
    return (FP_MAX_W'(1) << (w - 1)) - FP_MAX_W'(1);
  endfunction

  function automatic logic [FP_MAX_W-1:0] fp_min(input int w);
    return FP_MAX_W'(1) << (w - 1);
  endfunction

endpackage

// File: rtl/fixed_point_saturating_subtractor_if.sv
// Operand/result stream bundle for the saturating subtractor.
// The slave modport is the block's view; the master modport is the producer/consumer side.
interface fixed_point_saturating_subtractor_if #(
  parameter int W = 16
) ();

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         out_sat;

  modport slave (
    input  in_valid, A, B, out_ready,
    output in_ready, out_valid, diff, out_sat
  );

  modport master (
    output in_valid, A, B, out_ready,
    input  in_ready, out_valid, diff, out_sat
  );

endinterface

// File: rtl/pipe_stage_reg.sv
// One-entry valid/ready register slice; accepts new data whenever empty or being drained,
// so back-to-back slices sustain one transfer per cycle without bubbles.
module pipe_stage_reg #(
  parameter int DW = 17
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [DW-1:0] in_data_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [DW-1:0] out_data_o
);

  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;

  assign in_ready_o = !valid_q || out_ready_i;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    valid_d = valid_q;
    data_d  = data_q;
    if (in_ready_o) begin
      valid_d = in_valid_i;
      if (in_valid_i) data_d = in_data_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      // NOTE: the payload is reset too, because downstream exposes it as diff and it must read 0 out of reset.
      data_q  <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

endmodule

// File: rtl/fixed_point_saturating_subtractor.sv
// Two-stage streaming saturating subtractor (diff = A - B) with a saturating clamp-event
// counter and sticky flag; S1 holds the full-precision difference, S2 clamps it on the way out.
module fixed_point_saturating_subtractor
  import fixed_point_saturating_subtractor_pkg::*;
#(
  parameter int W       = 16,
  parameter int COUNT_W = 16
) (
  input  logic                                  clk,
  input  logic                                  reset,
  fixed_point_saturating_subtractor_if.slave    bus,
  input  logic                                  clear_count,
  output logic [COUNT_W-1:0]                    sat_count,
  output logic                                  sat_sticky
);

  localparam logic [FP_MAX_W-1:0] MAX_WIDE = fp_max(W);
  localparam logic [FP_MAX_W-1:0] MIN_WIDE = fp_min(W);
  localparam logic [W-1:0]        SAT_MAX  = MAX_WIDE[W-1:0];
  localparam logic [W-1:0]        SAT_MIN  = MIN_WIDE[W-1:0];

  logic [W:0]   raw_in, s1_data, s2_data;
  logic         s1_valid, s2_ready, s2_valid;
  logic [W-1:0] diff_sat;
  logic         sat_flag;

  // One extra bit of headroom makes the difference exact; overflow shows up in the top two bits.
  assign raw_in = {bus.A[W-1], bus.A} - {bus.B[W-1], bus.B};

  pipe_stage_reg #(.DW(W + 1)) u_s1 (
    .clk         (clk),
    .reset       (reset),
    .in_valid_i  (bus.in_valid),
    .in_ready_o  (bus.in_ready),
    .in_data_i   (raw_in),
    .out_valid_o (s1_valid),
    .out_ready_i (s2_ready),
    .out_data_o  (s1_data)
  );

  pipe_stage_reg #(.DW(W + 1)) u_s2 (
    .clk         (clk),
    .reset       (reset),
    .in_valid_i  (s1_valid),
    .in_ready_o  (s2_ready),
    .in_data_i   (s1_data),
    .out_valid_o (s2_valid),
    .out_ready_i (bus.out_ready),
    .out_data_o  (s2_data)
  );

  always_comb begin
    diff_sat = s2_data[W-1:0];
    sat_flag = 1'b0;
    case (s2_data[W:W-1])
      SAT_CODE_POS: begin
        diff_sat = SAT_MAX;
        sat_flag = 1'b1;
      end
      SAT_CODE_NEG: begin
        diff_sat = SAT_MIN;
        sat_flag = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.out_valid = s2_valid;
  assign bus.diff      = diff_sat;
  assign bus.out_sat   = sat_flag;

  logic [COUNT_W-1:0] sat_count_q, sat_count_d;
  logic               sat_sticky_q, sat_sticky_d;
  logic               sat_handoff;

  assign sat_handoff = s2_valid && bus.out_ready && sat_flag;

  // Clear wins over a same-cycle event; the count pins at all-ones instead of wrapping.
  always_comb begin
    sat_count_d  = sat_count_q;
    sat_sticky_d = sat_sticky_q;
    if (clear_count) begin
      sat_count_d  = '0;
      sat_sticky_d = 1'b0;
    end else if (sat_handoff) begin
      sat_sticky_d = 1'b1;
      if (sat_count_q != '1) sat_count_d = sat_count_q + COUNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sat_count_q  <= '0;
      sat_sticky_q <= 1'b0;
    end else begin
      sat_count_q  <= sat_count_d;
      sat_sticky_q <= sat_sticky_d;
    end
  end

  assign sat_count  = sat_count_q;
  assign sat_sticky = sat_sticky_q;

endmodule

// File: tb/tb_fixed_point_saturating_subtractor.sv
// Bench for the saturating subtractor: a driver feeds a pending queue, a negedge monitor
// scores every handoff against an integer-arithmetic reference and a clamp-event count model.
module tb_fixed_point_saturating_subtractor;

  localparam int W  = 16;
  localparam int CW = 16;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] diff;
    logic        sat;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          clear_count = 1'b0;
  logic [CW-1:0] sat_count;
  logic          sat_sticky;

  fixed_point_saturating_subtractor_if #(.W(W)) bus ();

  fixed_point_saturating_subtractor #(.W(W), .COUNT_W(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .clear_count (clear_count),
    .sat_count   (sat_count),
    .sat_sticky  (sat_sticky)
  );

  always #5 clk = ~clk;

  vec_t pend_q[$];
  vec_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   rnd = 0, hold_ready = 0, clear_req = 0;
  int   mcnt = 0;
  bit   msticky = 0;
  bit   was_stalled = 0, saw_clr_sat = 0, mon_hs;
  logic [15:0] last_diff;
  logic        last_sat;
  vec_t mon_e;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic vec_t ref_sub(input logic [15:0] a, input logic [15:0] b);
    vec_t v;
    int   ai, bi, d;
    ai = $signed(a);
    bi = $signed(b);
    d  = ai - bi;
    v.a = a;
    v.b = b;
    if (d > 32767) begin
      v.diff = 16'h7FFF;
      v.sat  = 1'b1;
    end else if (d < -32768) begin
      v.diff = 16'h8000;
      v.sat  = 1'b1;
    end else begin
      v.diff = d[15:0];
      v.sat  = 1'b0;
    end
    return v;
  endfunction

  task automatic push_pair(input logic [15:0] a, input logic [15:0] b);
    pend_q.push_back(ref_sub(a, b));
  endtask

  task automatic push_exp(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] d, input logic s);
    vec_t v;
    v.a = a; v.b = b; v.diff = d; v.sat = s;
    pend_q.push_back(v);
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k = 0;
    while ((pend_q.size() != 0 || exp_q.size() != 0) && k < budget) begin
      wait_neg(1);
      k++;
    end
    check(tag, (pend_q.size() == 0 && exp_q.size() == 0), 1);
  endtask

  function automatic logic [15:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      2:       return 16'h0000;
      3:       return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  // Driver: inputs change 1 unit after the rising edge.
  initial begin
    bus.in_valid  = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = hold_ready ? 1'b0 : (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
      clear_count   = clear_req || (rnd && $urandom_range(0, 499) == 0);
      clear_req     = 0;
      if (pend_q.size() > 0 && (!rnd || $urandom_range(0, 2) != 0)) begin
        bus.in_valid = 1'b1;
        bus.A        = pend_q[0].a;
        bus.B        = pend_q[0].b;
      end else begin
        bus.in_valid = 1'b0;
        bus.A        = 16'($urandom);
        bus.B        = 16'($urandom);
      end
    end
  end

  // Monitor: at the falling edge, decide which transfers the next rising edge performs.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        was_stalled = 0;
      end else begin
        if (was_stalled) begin
          check("stall_valid", bus.out_valid, 1);
          check("stall_diff", bus.diff, last_diff);
          check("stall_sat", bus.out_sat, last_sat);
        end
        check("in_ready", bus.in_ready, !(exp_q.size() == 2 && !bus.out_ready));
        if (bus.out_valid && exp_q.size() == 0) check("spurious_valid", bus.out_valid, 0);
        mon_hs = bus.out_valid && bus.out_ready && exp_q.size() > 0;
        if (mon_hs) begin
          mon_e = exp_q.pop_front();
          check("diff", bus.diff, mon_e.diff);
          check("out_sat", bus.out_sat, mon_e.sat);
        end
        if (clear_count) begin
          mcnt    = 0;
          msticky = 0;
          if (mon_hs && mon_e.sat) saw_clr_sat = 1;
        end else if (mon_hs && mon_e.sat) begin
          msticky = 1;
          if (mcnt < 65535) mcnt++;
        end
        if (bus.in_valid && bus.in_ready && pend_q.size() > 0) exp_q.push_back(pend_q.pop_front());
        was_stalled = bus.out_valid && !bus.out_ready;
        last_diff   = bus.diff;
        last_sat    = bus.out_sat;
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    wait_neg(2);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_diff", bus.diff, 0);
    check("rst_out_sat", bus.out_sat, 0);
    check("rst_sat_count", sat_count, 0);
    check("rst_sticky", sat_sticky, 0);
    reset = 1'b0;
    wait_neg(1);

    // Basic difference and two-cycle latency.
    push_exp(16'd100, 16'd30, 16'd70, 1'b0);
    wait_neg(2);
    check("lat_early", bus.out_valid, 0);
    wait_neg(1);
    check("lat_exact", bus.out_valid, 1);
    check("t1_diff", bus.diff, 16'd70);
    wait_idle("t1_idle", 20);

    // Boundary saturation, streamed back to back.
    push_exp(16'h8000, 16'h0001, 16'h8000, 1'b1);
    push_exp(16'h0000, 16'h8000, 16'h7FFF, 1'b1);
    push_exp(16'h8000, 16'h8000, 16'h0000, 1'b0);
    wait_neg(5);
    check("no_bubble", (pend_q.size() == 0 && exp_q.size() == 0), 1);
    wait_neg(1);
    check("t2_count", sat_count, 2);
    check("t2_sticky", sat_sticky, 1);

    // Mid-stream stall of five cycles.
    for (int i = 0; i < 8; i++) push_pair(16'(i * 4099 - 20000), 16'(i * 777 + 5));
    wait_neg(2);
    hold_ready = 1;
    wait_neg(5);
    check("stall_in_ready", bus.in_ready, 0);
    check("stall_depth", exp_q.size(), 2);
    check("stall_out_valid", bus.out_valid, 1);
    hold_ready = 0;
    wait_idle("t3_idle", 40);

    // Counter pinning at all-ones.
    wait_neg(1);
    force dut.sat_count_q = 16'hFFFE;
    mcnt = 16'hFFFE;
    @(posedge clk);
    #1;
    release dut.sat_count_q;
    wait_neg(1);
    for (int i = 0; i < 3; i++) push_pair(16'h8000, 16'h0001);
    wait_idle("t4_idle", 40);
    wait_neg(1);
    check("cnt_pinned", sat_count, 16'hFFFF);
    check("cnt_model_pin", sat_count, mcnt);

    // clear_count coinciding with a saturated handoff.
    push_pair(16'h8000, 16'h0001);
    wait_neg(2);
    clear_req = 1;
    wait_neg(2);
    check("clr_hit", saw_clr_sat, 1);
    check("clr_count", sat_count, 0);
    check("clr_sticky", sat_sticky, 0);

    // Asynchronous reset with both stages occupied.
    push_pair(16'd1000, 16'd1);
    push_pair(16'h8000, 16'h7FFF);
    hold_ready = 1;
    wait_neg(4);
    check("pre_reset_full", exp_q.size(), 2);
    reset = 1'b1;
    #1;
    check("async_out_valid", bus.out_valid, 0);
    check("async_in_ready", bus.in_ready, 1);
    pend_q.delete();
    exp_q.delete();
    mcnt       = 0;
    msticky    = 0;
    hold_ready = 0;
    wait_neg(2);
    check("post_rst_diff", bus.diff, 0);
    check("post_rst_count", sat_count, 0);
    reset = 1'b0;
    wait_neg(1);
    push_exp(16'h1234, 16'h0234, 16'h1000, 1'b0);
    wait_idle("post_rst_idle", 20);

    // Randomized traffic with random stalls and occasional clears.
    rnd = 1;
    for (int i = 0; i < 10000; i++) push_pair(pick_operand(), pick_operand());
    wait_idle("rand_idle", 60000);
    rnd = 0;
    wait_neg(2);
    check("rand_count", sat_count, mcnt);
    check("rand_sticky", sat_sticky, msticky);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
